// File: rtl/nvme_doorbell_sched.sv
// nvme_doorbell_sched: captures and coalesces four doorbell pointer slots and
// issues them round-robin as single-beat writes, with completion timeout.
module nvme_doorbell_sched #(
  parameter logic [63:0] BASE_ADDR_BAR = 64'h0,
  parameter logic [31:0] DB_OFFSET     = 32'h1000,
  parameter logic [31:0] DB_STRIDE     = 32'd4,
  parameter logic [15:0] WR_TIMEOUT    = 16'd4096
) (
  input  logic        clk_in,
  input  logic        areset_n,
  input  logic [3:0]  db_valid,
  input  logic [63:0] db_value,
  output logic [3:0]  db_pending,
  output logic [3:0]  db_sent,
  input  logic        wr_ready,
  output logic        wr_req,
  output logic [63:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_done,
  output logic        wr_error,
  input  logic        err_clr,
  output logic [15:0] coalesce_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  pending, pending_nxt;
  logic [15:0] value [4];
  logic [1:0]  last_grant;
  logic [1:0]  grant_idx;
  logic [1:0]  sel_idx;
  logic [1:0]  cand;
  logic        sel_found;
  logic [15:0] timer;
  logic        grant;
  logic        timeout;
  logic        done_ok;
  logic [2:0]  coal_inc;
  logic [16:0] coal_sum;

  assign db_pending = pending;

  // Round-robin pick: first pending slot searching upward from last_grant+1.
  always_comb begin
    sel_idx   = last_grant;
    sel_found = 1'b0;
    cand      = last_grant;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!sel_found && pending[cand]) begin
        sel_idx   = cand;
        sel_found = 1'b1;
      end
    end
  end

  // FSM next state and the single-cycle grant/timeout/completion events.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    timeout   = 1'b0;
    done_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found && wr_ready) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (wr_done) begin
          done_ok   = 1'b1;
          state_nxt = DONE;
        end else if (timer == WR_TIMEOUT - 16'd1) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pending bits: grant clears, timeout re-arms, any strobe sets; count
  // strobes that overwrite a still-pending value of a slot not being granted.
  always_comb begin
    pending_nxt = pending;
    coal_inc    = '0;
    if (grant)
      pending_nxt[sel_idx] = 1'b0;
    if (timeout)
      pending_nxt[grant_idx] = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (db_valid[i]) begin
        pending_nxt[i] = 1'b1;
        if (pending[i] && !(grant && sel_idx == 2'(i)))
          coal_inc = coal_inc + 3'd1;
      end
    end
    coal_sum = {1'b0, coalesce_cnt} + {14'd0, coal_inc};
  end

  // Latest pointer value per slot.
  always_ff @(posedge clk_in) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (!areset_n)
        value[i] <= '0;
      else if (db_valid[i])
        value[i] <= db_value[16*i +: 16];
    end
  end

  // State, pending, registered write-master outputs, timer and status.
  always_ff @(posedge clk_in) begin
    if (!areset_n) begin
      state        <= IDLE;
      pending      <= '0;
      last_grant   <= 2'd3;
      grant_idx    <= '0;
      timer        <= '0;
      wr_req       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      db_sent      <= '0;
      wr_error     <= 1'b0;
      coalesce_cnt <= '0;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      coalesce_cnt <= coal_sum[16] ? '1 : coal_sum[15:0];
      wr_req       <= grant;
      db_sent      <= done_ok ? (4'b0001 << grant_idx) : 4'b0000;
      if (grant) begin
        grant_idx <= sel_idx;
        wr_addr   <= BASE_ADDR_BAR + {32'd0, DB_OFFSET}
                   + ({32'd0, DB_STRIDE} * {62'd0, sel_idx});
        wr_data   <= {16'd0, value[sel_idx]};
      end
      if (state == ISSUE)
        timer <= '0;
      else if (state == WAIT)
        timer <= timer + 16'd1;
      // A timeout in the same cycle as err_clr keeps the flag set.
      if (timeout)
        wr_error <= 1'b1;
      else if (err_clr)
        wr_error <= 1'b0;
      if (state == DONE)
        last_grant <= grant_idx;
    end
  end

endmodule

// File: doc/nvme_doorbell_sched.md
Name: nvme_doorbell_sched

Overview:
Schedules NVMe doorbell writes from four queue-pointer sources onto one single-beat system write master:
- slot 0: admin SQ tail
- slot 1: admin CQ head
- slot 2: IO SQ tail
- slot 3: IO CQ head

Each slot holds its latest pointer value and coalesces updates that arrive while a write is pending. Slots are served round-robin, and the block waits for write completion, with a timeout, before issuing the next write. It sits between the queue managers and the system write master in place of per-source request/ack pairs.

Parameters:
- BASE_ADDR_BAR, 64'h0, BAR0 base address of the controller.
- DB_OFFSET, 32'h1000, offset of the first doorbell register.
- DB_STRIDE, 32'd4, byte stride between doorbells (CAP.DSTRD).
- WR_TIMEOUT, 16'd4096, maximum cycles in WAIT before the write is abandoned.

Ports:
- clk_in  in  1  clock
- areset_n  in  1  reset, synchronous, active-low
- db_valid  in  4  one-cycle update strobe per slot
- db_value  in  64  new pointers; slot i uses bits [16i+15:16i]
- db_pending  out  4  slot holds a value not yet written
- db_sent  out  4  one-cycle pulse when slot's write completes
- wr_ready  in  1  write master idle
- wr_req  out  1  one-cycle write request
- wr_addr  out  64  doorbell address, stable from wr_req until the state returns to IDLE
- wr_data  out  32  {16'd0, pointer}
- wr_done  in  1  one-cycle completion from the master
- wr_error  out  1  sticky timeout flag
- err_clr  in  1  clears wr_error
- coalesce_cnt  out  16  count of overwritten pending updates; saturates at 16'hFFFF

Behaviour:
Reset:
- Applies at any time, including mid-transfer; takes priority over everything.
- State goes to IDLE; all pending bits, values, db_sent, wr_req, wr_error and coalesce_cnt go to 0.
- wr_addr and wr_data go to 0.
- The round-robin pointer last_grant goes to 3, so slot 0 has first priority.
- Pending updates are discarded.

Slot capture (every cycle, all slots in parallel):
- db_valid[i] loads value[i] and sets pending[i].
- If pending[i] was already 1 and slot i is not being granted this cycle, coalesce_cnt increments by 1.
- Several slots may strobe in the same cycle; all are captured.

FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Grants when pending != 0 and wr_ready = 1.
  - Grant target g is the first pending slot found searching upward from last_grant+1, modulo 4.
  - On grant: latch wr_addr = BASE_ADDR_BAR + DB_OFFSET + g*DB_STRIDE and wr_data = {16'd0, value[g]}, clear pending[g], go to ISSUE.
  - If db_valid[g] is asserted in the grant cycle, pending[g] stays 1 and the new value is kept for a later write. The granted data is the pre-strobe value.
- ISSUE: wr_req = 1 for exactly this cycle; go to WAIT and clear the timer.
- WAIT:
  - Timer increments each cycle.
  - wr_done: pulse db_sent[g] next cycle, go to DONE.
  - Timer reaches WR_TIMEOUT-1 without wr_done: set wr_error, set pending[g] again (unless a newer value is already pending), go to DONE.
  - wr_done in the same cycle as the timeout: treat as success.
- DONE: last_grant = g; go to IDLE.
- wr_done outside WAIT is ignored.

Latency and throughput:
- With db_valid[i] at cycle 0, the FSM idle and wr_ready = 1: pending[i] is seen at cycle 1, grant at cycle 1, wr_req at cycle 2.
- Back-to-back minimum is 4 cycles per write plus the master's latency.

Error flag:
- err_clr clears wr_error next cycle.
- A simultaneous new timeout wins and wr_error stays set.

Outputs:
- All outputs are registered; db_pending reflects the pending bits directly.

Test Plan:
- Single write: slot 2 strobes value 16'h0005, wr_ready = 1, master returns wr_done 3 cycles after wr_req → one wr_req at cycle 2 with wr_addr = BASE+0x1008 and wr_data = 32'h5; db_sent[2] pulses; db_pending = 0.
- Coalescing: wr_ready = 0; slot 0 strobes 1, 2, 3; then wr_ready = 1 → exactly one write of 32'h3 to BASE+0x1000; coalesce_cnt = 2.
- Fairness: all four slots pending with distinct values, wr_done always returns 1 cycle after wr_req → grant order 0,1,2,3; a re-strobe of slot 0 after its grant is served after slot 3.
- Strobe in grant cycle: slot 1 granted with value 7 while db_valid[1] carries 9 → write of 7 completes, db_pending[1] stays 1, second write of 9 follows.
- Timeout: wr_done never returned, WR_TIMEOUT = 16 → wr_error sets 16 cycles after entering WAIT; slot re-pended and retried; err_clr clears wr_error.
- Reset mid-operation: areset_n low during WAIT with pending = 4'b1010 → next cycle state is IDLE, pending = 0, wr_req = 0; after release, no write until a new strobe.
